// File: rtl/raisin64_pkg.sv
// Shared constants for the raisin64 writeback path: unit indices, widths and
// pointer helpers used by the writeback arbiter.
package raisin64_pkg;

  localparam int unsigned NUM_WB_UNITS = 5;
  localparam int unsigned REG_NUM_W    = 6;
  localparam int unsigned UNIT_IDX_W   = 3;

  localparam logic [UNIT_IDX_W-1:0] UNIT_ALU1    = 3'd0;
  localparam logic [UNIT_IDX_W-1:0] UNIT_ALU2    = 3'd1;
  localparam logic [UNIT_IDX_W-1:0] UNIT_ADVINT  = 3'd2;
  localparam logic [UNIT_IDX_W-1:0] UNIT_MEMUNIT = 3'd3;
  localparam logic [UNIT_IDX_W-1:0] UNIT_BRANCH  = 3'd4;

  // Reduce a 0..8 sum of pointer plus offset back into the 0..4 unit range.
  function automatic logic [UNIT_IDX_W-1:0] wb_wrap_idx(input logic [3:0] s);
    if (s >= 4'(NUM_WB_UNITS)) return UNIT_IDX_W'(s - 4'(NUM_WB_UNITS));
    else                       return UNIT_IDX_W'(s);
  endfunction

  function automatic logic [UNIT_IDX_W-1:0] wb_next_idx(input logic [UNIT_IDX_W-1:0] i);
    if (i == UNIT_BRANCH) return UNIT_ALU1;
    else                  return i + 3'd1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Rotating-priority first-one finder over the five writeback requesters,
// scanning upward from ptr and wrapping modulo five.
module rr_select
  import raisin64_pkg::*;
(
  input  logic [NUM_WB_UNITS-1:0] req,
  input  logic [UNIT_IDX_W-1:0]   ptr,
  output logic [UNIT_IDX_W-1:0]   idx_c,
  output logic                    found_c
);

  // Scan from the far end so the nearest hit in scan order is written last.
  always_comb begin
    logic [UNIT_IDX_W-1:0] pos;
    idx_c   = '0;
    found_c = 1'b0;
    pos     = '0;
    for (int i = int'(NUM_WB_UNITS) - 1; i >= 0; i--) begin
      pos = wb_wrap_idx(4'(ptr) + 4'(i));
      if (req[pos]) begin
        idx_c   = pos;
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to two register-file write ports per cycle
// among alu1, alu2, advint (dual result), memunit and branch.
module wb_arbiter
  import raisin64_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RR_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu1_req,
  input  logic [REG_NUM_W-1:0] alu1_rn,
  input  logic [DATA_W-1:0]    alu1_data,
  input  logic                 alu2_req,
  input  logic [REG_NUM_W-1:0] alu2_rn,
  input  logic [DATA_W-1:0]    alu2_data,
  input  logic                 memunit_req,
  input  logic [REG_NUM_W-1:0] memunit_rn,
  input  logic [DATA_W-1:0]    memunit_data,
  input  logic                 branch_req,
  input  logic [REG_NUM_W-1:0] branch_rn,
  input  logic [DATA_W-1:0]    branch_data,
  input  logic                 advint_req,
  input  logic [REG_NUM_W-1:0] advint_rn,
  input  logic [REG_NUM_W-1:0] advint_rn2,
  input  logic [DATA_W-1:0]    advint_data,
  input  logic [DATA_W-1:0]    advint_data2,
  output logic                 alu1_ack,
  output logic                 alu2_ack,
  output logic                 advint_ack,
  output logic                 memunit_ack,
  output logic                 branch_ack,
  output logic                 wr1_en,
  output logic                 wr2_en,
  output logic [REG_NUM_W-1:0] wr1_rn,
  output logic [REG_NUM_W-1:0] wr2_rn,
  output logic [DATA_W-1:0]    wr1_data,
  output logic [DATA_W-1:0]    wr2_data,
  output logic [REG_NUM_W-1:0] reg1_finished,
  output logic [REG_NUM_W-1:0] reg2_finished
);

  logic [NUM_WB_UNITS-1:0] req_v;
  logic [NUM_WB_UNITS-1:0] req2_v;
  logic [NUM_WB_UNITS-1:0] grant;
  logic [REG_NUM_W-1:0]    rn_a   [NUM_WB_UNITS];
  logic [DATA_W-1:0]       data_a [NUM_WB_UNITS];
  logic [UNIT_IDX_W-1:0]   rr_ptr;
  logic [UNIT_IDX_W-1:0]   scan_ptr;
  logic [UNIT_IDX_W-1:0]   ptr_nxt;
  logic [UNIT_IDX_W-1:0]   idx1;
  logic [UNIT_IDX_W-1:0]   idx2;
  logic                    found1;
  logic                    found2;
  logic                    adv_first;
  logic [REG_NUM_W-1:0]    s1_rn;
  logic [REG_NUM_W-1:0]    s2_rn;
  logic [DATA_W-1:0]       s1_data;
  logic [DATA_W-1:0]       s2_data;

  // Requests are masked during reset so nothing is acked or written.
  always_comb begin
    req_v = rst ? '0 : {branch_req, memunit_req, advint_req, alu2_req, alu1_req};
    rn_a[UNIT_ALU1]      = alu1_rn;
    rn_a[UNIT_ALU2]      = alu2_rn;
    rn_a[UNIT_ADVINT]    = advint_rn;
    rn_a[UNIT_MEMUNIT]   = memunit_rn;
    rn_a[UNIT_BRANCH]    = branch_rn;
    data_a[UNIT_ALU1]    = alu1_data;
    data_a[UNIT_ALU2]    = alu2_data;
    data_a[UNIT_ADVINT]  = advint_data;
    data_a[UNIT_MEMUNIT] = memunit_data;
    data_a[UNIT_BRANCH]  = branch_data;
  end

  assign scan_ptr  = (RR_EN != 0) ? rr_ptr : UNIT_ALU1;
  assign adv_first = found1 && (idx1 == UNIT_ADVINT);

  rr_select u_sel1 (
    .req     (req_v),
    .ptr     (scan_ptr),
    .idx_c   (idx1),
    .found_c (found1)
  );

  // Second slot: drop the first pick, advint (needs both slots) and any
  // requester whose nonzero destination collides with the first grant.
  always_comb begin
    req2_v = '0;
    for (int unsigned i = 0; i < NUM_WB_UNITS; i++) begin
      if (found1 && !adv_first && req_v[i]
          && (UNIT_IDX_W'(i) != idx1) && (UNIT_IDX_W'(i) != UNIT_ADVINT)
          && !((rn_a[i] != '0) && (rn_a[i] == rn_a[idx1])))
        req2_v[i] = 1'b1;
    end
  end

  rr_select u_sel2 (
    .req     (req2_v),
    .ptr     (scan_ptr),
    .idx_c   (idx2),
    .found_c (found2)
  );

  always_comb begin
    grant   = '0;
    s1_rn   = '0;
    s1_data = '0;
    s2_rn   = '0;
    s2_data = '0;
    ptr_nxt = rr_ptr;
    if (found1) begin
      grant[idx1] = 1'b1;
      s1_rn       = rn_a[idx1];
      s1_data     = data_a[idx1];
      ptr_nxt     = wb_next_idx(idx1);
    end
    if (adv_first) begin
      s2_rn   = advint_rn2;
      s2_data = advint_data2;
    end else if (found2) begin
      grant[idx2] = 1'b1;
      s2_rn       = rn_a[idx2];
      s2_data     = data_a[idx2];
      ptr_nxt     = wb_next_idx(idx2);
    end
    // A granted rn==0 result is discarded: no write, no data.
    if (s1_rn == '0) s1_data = '0;
    if (s2_rn == '0) s2_data = '0;
  end

  assign alu1_ack    = grant[UNIT_ALU1];
  assign alu2_ack    = grant[UNIT_ALU2];
  assign advint_ack  = grant[UNIT_ADVINT];
  assign memunit_ack = grant[UNIT_MEMUNIT];
  assign branch_ack  = grant[UNIT_BRANCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr1_en        <= 1'b0;
      wr2_en        <= 1'b0;
      wr1_rn        <= '0;
      wr2_rn        <= '0;
      wr1_data      <= '0;
      wr2_data      <= '0;
      reg1_finished <= '0;
      reg2_finished <= '0;
      rr_ptr        <= UNIT_ALU1;
    end else begin
      wr1_en        <= (s1_rn != '0);
      wr2_en        <= (s2_rn != '0);
      wr1_rn        <= s1_rn;
      wr2_rn        <= s2_rn;
      wr1_data      <= s1_data;
      wr2_data      <= s2_data;
      reg1_finished <= s1_rn;
      reg2_finished <= s2_rn;
      rr_ptr        <= ptr_nxt;
    end
  end

endmodule
